// File: rtl/pc_sequencer_if.sv
// Control/status bundle for pc_sequencer: step/jump/halt requests in, PC and timing state out.
interface pc_sequencer_if #(
   parameter int unsigned T_STEPS = 6
);
   logic               en;
   logic               jmp;
   logic [3:0]         jmp_addr;
   logic               hlt;
   logic [3:0]         pc;
   logic [T_STEPS-1:0] t_state;
   logic               halted;
   logic               wrap;

   modport master (
      output en, jmp, jmp_addr, hlt,
      input  pc, t_state, halted, wrap
   );

   modport slave (
      input  en, jmp, jmp_addr, hlt,
      output pc, t_state, halted, wrap
   );
endinterface

// File: rtl/pc_sequencer.sv
// Ring-counter timed 4-bit program counter: increments in T2, optionally jumps in T4.
// Halt logic is built only when PC_SEQ_HALT_EN is defined.
module pc_sequencer #(
   parameter int unsigned T_STEPS = 6
) (
   input logic          clk,
   input logic          rst,
   pc_sequencer_if.slave bus
);

   localparam logic [T_STEPS-1:0] TInit = {{(T_STEPS-1){1'b0}}, 1'b1};

   logic [3:0]         pc_q, pc_d;
   logic [T_STEPS-1:0] t_q, t_d;
   logic               wrap_q, wrap_d;
   logic               step;
   logic               adv;
   logic               pc_load;
   logic [3:0]         pc_inc;
   logic [3:0]         pc_next;

`ifdef PC_SEQ_HALT_EN
   typedef enum logic {StRun, StHalt} state_e;
   state_e state_q, state_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   // HALT is sticky: only reset returns to RUN.
   always_comb begin
      state_d = state_q;
      if (state_q == StRun && bus.en && bus.hlt) begin
         state_d = StHalt;
      end
   end

   assign step       = bus.en && (state_q == StRun);
   assign adv        = step && !bus.hlt;
   assign bus.halted = (state_q == StHalt);
`else
   logic unused_hlt;
   assign unused_hlt = bus.hlt;
   assign step       = bus.en;
   assign adv        = step;
   assign bus.halted = 1'b0;
`endif

   // Single 2:1 select: jump target in T4, incrementer otherwise.
   assign pc_inc  = pc_q + 4'd1;
   assign pc_next = t_q[3] ? bus.jmp_addr : pc_inc;
   assign pc_load = adv && (t_q[1] || (t_q[3] && bus.jmp));

   always_comb begin
      pc_d   = pc_q;
      t_d    = t_q;
      wrap_d = 1'b0;
      if (adv) begin
         t_d = {t_q[T_STEPS-2:0], t_q[T_STEPS-1]};
         if (pc_load) begin
            pc_d = pc_next;
         end
         wrap_d = t_q[1] && (pc_q == 4'hF);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= 4'h0;
         t_q    <= TInit;
         wrap_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         t_q    <= t_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.pc      = pc_q;
   assign bus.t_state = t_q;
   assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: phase/PC model checked every cycle, plus directed literals.
module tb_pc_sequencer;

   localparam int unsigned T = 6;
`ifdef PC_SEQ_HALT_EN
   localparam bit HaltEn = 1'b1;
`else
   localparam bit HaltEn = 1'b0;
`endif

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // Model: timing phase index (0 = T1), PC value, halt flag, wrap pulse.
   int   ph;
   int   mpc;
   bit   mhalt;
   bit   mwrap;

   pc_sequencer_if #(.T_STEPS(T)) bus ();

   pc_sequencer #(.T_STEPS(T)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      ph    = 0;
      mpc   = 0;
      mhalt = 1'b0;
      mwrap = 1'b0;
   endtask

   task automatic model_edge(input bit e, input bit j, input logic [3:0] a, input bit h);
      mwrap = 1'b0;
      if (mhalt || !e) begin
         // everything holds
      end else if (h && HaltEn) begin
         mhalt = 1'b1;
      end else begin
         if (ph == 1) begin
            mwrap = (mpc == 15);
            mpc   = (mpc + 1) % 16;
         end else if (ph == 3 && j) begin
            mpc = int'(a);
         end
         ph = (ph + 1) % T;
      end
   endtask

   task automatic compare_all();
      chk("pc", {28'd0, bus.pc}, mpc);
      chk("t_state", {26'd0, bus.t_state}, 32'd1 << ph);
      chk("halted", {31'd0, bus.halted}, {31'd0, mhalt});
      chk("wrap", {31'd0, bus.wrap}, {31'd0, mwrap});
   endtask

   task automatic step(input bit e, input bit j, input logic [3:0] a, input bit h);
      bus.en       = e;
      bus.jmp      = j;
      bus.jmp_addr = a;
      bus.hlt      = h;
      @(posedge clk);
      model_edge(e, j, a, h);
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 4'h0, 1'b0);
   endtask

   // Reset pulse placed between edges; outputs must change without a clock.
   task automatic async_reset();
      #1 rst = 1'b1;
      #1;
      model_reset();
      compare_all();
      #1 rst = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      bus.en = 1'b0;
      bus.jmp = 1'b0;
      bus.jmp_addr = 4'h0;
      bus.hlt = 1'b0;
      rst = 1'b1;
      model_reset();
      #12;
      chk("reset_pc", {28'd0, bus.pc}, 32'h0);
      chk("reset_t", {26'd0, bus.t_state}, 32'h1);
      chk("reset_halted", {31'd0, bus.halted}, 32'h0);
      chk("reset_wrap", {31'd0, bus.wrap}, 32'h0);
      rst = 1'b0;
      #1;

      // Twelve enabled edges: two full rotations, two increments.
      run(1);
      chk("first_edge_t2", {26'd0, bus.t_state}, 32'h2);
      chk("first_edge_pc", {28'd0, bus.pc}, 32'h0);
      run(1);
      chk("pc_after_t2", {28'd0, bus.pc}, 32'h1);
      run(6);
      chk("pc_after_2nd_t2", {28'd0, bus.pc}, 32'h2);
      run(4);
      chk("t1_after_12", {26'd0, bus.t_state}, 32'h1);

      // Overflow: 15 increments in 90 edges, then the 16th wraps.
      async_reset();
      run(90);
      chk("pc_15", {28'd0, bus.pc}, 32'hF);
      run(2);
      chk("wrap_pc0", {28'd0, bus.pc}, 32'h0);
      chk("wrap_pulse", {31'd0, bus.wrap}, 32'h1);
      run(1);
      chk("wrap_drop", {31'd0, bus.wrap}, 32'h0);

      // Jump held the whole sequence lands only in T4; jump to 0 gives no wrap.
      async_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 4'hA, 1'b0);
      chk("jmp_ignored_pc", {28'd0, bus.pc}, 32'h1);
      step(1'b1, 1'b1, 4'hA, 1'b0);
      chk("jmp_loaded", {28'd0, bus.pc}, 32'hA);
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 4'hA, 1'b0);
      chk("jmp_hold", {28'd0, bus.pc}, 32'hA);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'h0, 1'b0);
      chk("jmp_zero_pc", {28'd0, bus.pc}, 32'h0);
      chk("jmp_zero_wrap", {31'd0, bus.wrap}, 32'h0);

      // hlt with jmp in T4.
      async_reset();
      run(3);
      step(1'b1, 1'b1, 4'hA, 1'b1);
      if (HaltEn) begin
         chk("halt_flag", {31'd0, bus.halted}, 32'h1);
         chk("halt_pc", {28'd0, bus.pc}, 32'h1);
         chk("halt_t", {26'd0, bus.t_state}, 32'h8);
      end else begin
         chk("nohalt_flag", {31'd0, bus.halted}, 32'h0);
         chk("nohalt_pc", {28'd0, bus.pc}, 32'hA);
      end
      for (int i = 0; i < 8; i++)
         step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));

      // Reset from HALT (or mid-sequence) with pc=7.
      async_reset();
      run(38);
      chk("pc_7", {28'd0, bus.pc}, 32'h7);
      step(1'b1, 1'b0, 4'h0, 1'b1);
      chk("hlt_pc7", {28'd0, bus.pc}, 32'h7);
      async_reset();
      chk("rst_pc", {28'd0, bus.pc}, 32'h0);
      chk("rst_t", {26'd0, bus.t_state}, 32'h1);
      chk("rst_halted", {31'd0, bus.halted}, 32'h0);
      run(2);
      chk("resume_pc", {28'd0, bus.pc}, 32'h1);

      // en=0 parked in T2.
      async_reset();
      run(1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'h5, 1'b1);
      chk("en0_t", {26'd0, bus.t_state}, 32'h2);
      chk("en0_pc", {28'd0, bus.pc}, 32'h0);
      chk("en0_wrap", {31'd0, bus.wrap}, 32'h0);
      run(1);
      chk("en1_pc", {28'd0, bus.pc}, 32'h1);

      // Random traffic with rare halts and occasional mid-cycle resets.
      async_reset();
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
              ($urandom_range(0, 63) == 0));
         if ($urandom_range(0, 99) == 0) async_reset();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
